ysyx_25030085_core_seq: RTL

YSYX_25030085_CORE_SEQ -- requirements
Module: ysyx_25030085_core_seq

---
 rtl/ysyx_25030085_pkg.sv | 21 ++
 rtl/ysyx_25030085_bus_wdt.sv | 40 ++++
 rtl/ysyx_25030085_core_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ysyx_25030085_pkg.sv
// ysyx_25030085_pkg
// Shared definitions for the multi-cycle core sequencer.
//   seq_state_e        : sequencer state encoding (S_ERR only when
//                        YSYX_25030085_SEQ_TIMEOUT_EN is defined)
//   DEF_TIMEOUT_CYCLES : default bus-wait limit for the watchdog
package ysyx_25030085_pkg;

    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4
`ifdef YSYX_25030085_SEQ_TIMEOUT_EN
        , S_ERR = 3'd5
`endif
    } seq_state_e;

endpackage

// File: rtl/ysyx_25030085_bus_wdt.sv
// ysyx_25030085_bus_wdt
// Bus-wait watchdog. Counts consecutive cycles spent waiting for a
// handshake and flags expiry on the TIMEOUT_CYCLES-th waiting cycle.
// Only instantiated when YSYX_25030085_SEQ_TIMEOUT_EN is defined.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   active  : sequencer is in a waiting state (FETCH or MEM)
//   restart : sequencer changes state this cycle; count restarts at 0
//   expired : current waiting cycle is the last one allowed
module ysyx_25030085_bus_wdt
    import ysyx_25030085_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic restart,
    output logic expired
);

    // Count never exceeds TIMEOUT_CYCLES-1, so clog2(TIMEOUT_CYCLES) bits suffice.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    assign expired = active && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || !active) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_25030085_core_seq.sv
// ysyx_25030085_core_seq
// Multi-cycle instruction sequencer: FETCH -> EXEC -> [MEM ->] WB.
// Optional bus timeout: define YSYX_25030085_SEQ_TIMEOUT_EN to enable the
// watchdog and the sticky ERR state; otherwise FETCH/MEM wait forever and
// err is tied low.
// Ports:
//   clk, rst             : clock (rising edge), async active-low reset
//   pc                   : current PC from the PC unit
//   ifu_req/ifu_addr     : fetch request and address (FETCH only)
//   ifu_rvalid/ifu_rdata : fetch response
//   inst                 : latched instruction
//   mem_read/mem_write/reg_write : decoded control flags
//   lsu_req/lsu_we/lsu_done      : data memory handshake (MEM only)
//   pc_we/reg_we         : writeback strobes (WB only)
//   retire_cnt           : retired-instruction counter (wraps)
//   err                  : sticky bus timeout flag
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | just out of reset, go fetch on the next clock
// S_FETCH | request instruction at pc, wait for ifu_rvalid
// S_EXEC  | one cycle for decode/ALU on the latched inst
// S_MEM   | data memory access, wait for lsu_done
// S_WB    | one cycle: pc_we, reg_we, count retirement
// S_ERR   | bus timeout, parked until reset (timeout build only)
module ysyx_25030085_core_seq
    import ysyx_25030085_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            ifu_req,
    output logic [XLEN-1:0] ifu_addr,
    input  logic            ifu_rvalid,
    input  logic [XLEN-1:0] ifu_rdata,
    output logic [XLEN-1:0] inst,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            reg_write,
    output logic            lsu_req,
    output logic            lsu_we,
    input  logic            lsu_done,
    output logic            pc_we,
    output logic            reg_we,
    output logic [XLEN-1:0] retire_cnt,
    output logic            err
);

    seq_state_e      state;
    seq_state_e      state_nxt;
    logic [XLEN-1:0] retire_q;

`ifdef YSYX_25030085_SEQ_TIMEOUT_EN
    logic wdt_expired;

    ysyx_25030085_bus_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_bus_wdt (
        .clk    (clk),
        .rst    (rst),
        .active (state == S_FETCH || state == S_MEM),
        .restart(state_nxt != state),
        .expired(wdt_expired)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are decoded from the state register so reset clears them at once.
    always_comb begin
        state_nxt = state;
        ifu_req   = 1'b0;
        ifu_addr  = '0;
        lsu_req   = 1'b0;
        lsu_we    = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                ifu_req  = 1'b1;
                ifu_addr = pc;
                if (ifu_rvalid) begin
                    state_nxt = S_EXEC;
                end
`ifdef YSYX_25030085_SEQ_TIMEOUT_EN
                else if (wdt_expired) begin
                    state_nxt = S_ERR;
                end
`endif
            end
            S_EXEC: state_nxt = (mem_read || mem_write) ? S_MEM : S_WB;
            S_MEM: begin
                lsu_req = 1'b1;
                lsu_we  = mem_write;
                if (lsu_done) begin
                    state_nxt = S_WB;
                end
`ifdef YSYX_25030085_SEQ_TIMEOUT_EN
                else if (wdt_expired) begin
                    state_nxt = S_ERR;
                end
`endif
            end
            S_WB: begin
                pc_we     = 1'b1;
                // Both load and store flags set is treated as a store: no regfile write.
                reg_we    = reg_write && !(mem_read && mem_write);
                state_nxt = S_FETCH;
            end
`ifdef YSYX_25030085_SEQ_TIMEOUT_EN
            S_ERR: state_nxt = S_ERR;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst <= '0;
        end else if (state == S_FETCH && ifu_rvalid) begin
            inst <= ifu_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q <= '0;
        end else if (state == S_WB) begin
            retire_q <= retire_q + 1'b1;
        end
    end

    assign retire_cnt = retire_q;

`ifdef YSYX_25030085_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (state_nxt == S_ERR) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
